// File: rtl/stream_seq_pkg.sv
// Shared definitions for the stream sequence parser: header layout,
// parser FSM states and the per-message flag bundle.
package stream_seq_pkg;

    localparam int LEN_OFF    = 0;
    localparam int STREAM_OFF = 2;
    localparam int SEQ_OFF    = 4;
    localparam int HDR_BYTES  = 8;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_BODY,
        ST_HOLD
    } parseState_t;

    typedef struct packed {
        logic        packetLost;
        logic [15:0] lostCount;
        logic        reorder;
        logic        lenErr;
        logic        truncated;
    } flags_t;

endpackage

// File: rtl/stream_seq_table.sv
// Table of last-seen sequence numbers per stream; classifies each header's
// sequence number as in-order, gap or reorder and maintains the entries.
module stream_seq_table
    import stream_seq_pkg::*;
#(
    parameter int NUM_STREAMS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookupEn,
    input  logic [15:0] lookupStream,
    input  logic [31:0] lookupSeq,
    output flags_t      flags
);
    localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    logic [NUM_STREAMS-1:0] entryValid;
    logic [15:0]            entryStream [NUM_STREAMS];
    logic [31:0]            entrySeq    [NUM_STREAMS];
    logic [IDX_W-1:0]       victim;
    logic [IDX_W-1:0]       hitIdx;
    logic [IDX_W-1:0]       freeIdx;
    logic [IDX_W-1:0]       wrIdx;
    logic                   hit;
    logic                   hasFree;
    logic                   doWrite;
    logic [31:0]            diff;
    logic [31:0]            diffM1;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        hit     = 1'b0;
        hasFree = 1'b0;
        hitIdx  = '0;
        freeIdx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (entryValid[i] && entryStream[i] == lookupStream) begin
                hit    = 1'b1;
                hitIdx = IDX_W'(i);
            end
            if (!entryValid[i]) begin
                hasFree = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        flags   = '0;
        doWrite = 1'b0;
        wrIdx   = hasFree ? freeIdx : victim;
        diff    = lookupSeq - entrySeq[hitIdx];
        diffM1  = diff - 32'd1;
        if (hit) begin
            wrIdx = hitIdx;
            if (diff == 32'd1) begin
                doWrite = 1'b1;
            end else if (!diff[31] && diff != 32'd0) begin
                doWrite          = 1'b1;
                flags.packetLost = 1'b1;
                flags.lostCount  = (|diffM1[31:16]) ? 16'hFFFF : diffM1[15:0];
            end else begin
                flags.reorder = 1'b1;
            end
        end else begin
            doWrite = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entryValid <= '0;
            victim     <= '0;
        end else if (lookupEn) begin
            if (doWrite) begin
                entryValid[wrIdx]  <= 1'b1;
                entryStream[wrIdx] <= lookupStream;
                entrySeq[wrIdx]    <= lookupSeq;
            end
            if (!hit && !hasFree) begin
                victim <= (victim == IDX_W'(NUM_STREAMS - 1)) ? '0 : victim + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_seq_parser.sv
// Length-prefixed message parser: header/payload FSM, byte packing and the
// output register, with per-stream sequence checking in stream_seq_table.
module stream_seq_parser
    import stream_seq_pkg::*;
#(
    parameter int BEAT_BYTES  = 4,
    parameter int OUT_BYTES   = 37,
    parameter int NUM_STREAMS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*BEAT_BYTES-1:0] dataIn,
    input  logic                    dataIn_val,
    input  logic                    dataIn_last,
    output logic                    dataIn_ready,
    output logic [8*OUT_BYTES-1:0]  dataOut,
    output logic [15:0]             dataOut_stream,
    output logic [31:0]             dataOut_seq,
    output logic [15:0]             dataOut_len,
    output logic                    dataOut_val,
    input  logic                    dataOut_ready,
    output logic                    packetLost,
    output logic [15:0]             lostCount,
    output logic                    reorder,
    output logic                    lenErr,
    output logic                    truncated
);
    localparam int HDR_BEATS  = HDR_BYTES / BEAT_BYTES;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    parseState_t               state, stateNext;
    logic [16:0]               beatCnt;
    logic [HDR_BYTES-1:0][7:0] hdrReg, hdrNext;
    logic [8*OUT_BYTES-1:0]    payBuf, payNext;
    flags_t                    tblFlags, tblFlagReg, curFlags, msgFlags, pendFlags, outFlags;
    logic [15:0]               pendLen, pendStream;
    logic [31:0]               pendSeq;
    logic                      fire, lastFire, hdrFinal, outFree;
    logic [31:0]               base, recv, avail, payRecv, expBeats;
    logic [15:0]               curLen, curStream, curOutLen;
    logic [31:0]               curSeq;
    logic                      curLenErr, curTrunc;

    assign dataIn_ready = (state != ST_HOLD);
    assign fire         = dataIn_val && dataIn_ready;
    assign lastFire     = fire && dataIn_last;
    assign hdrFinal     = fire && (beatCnt == 17'(HDR_BEATS - 1));
    assign outFree      = !dataOut_val || dataOut_ready;

    // Header and payload are rebuilt from zero on the first beat of a message.
    always_comb begin
        base    = 32'(beatCnt) << BEAT_SHIFT;
        hdrNext = (beatCnt == '0) ? '0 : hdrReg;
        payNext = (beatCnt == '0) ? '0 : payBuf;
        for (int h = 0; h < HDR_BYTES; h++) begin
            for (int k = 0; k < BEAT_BYTES; k++) begin
                if (base + 32'(k) == 32'(h)) hdrNext[h] = dataIn[8*BEAT_BYTES-1-8*k -: 8];
            end
        end
        curLen    = {hdrNext[LEN_OFF+1], hdrNext[LEN_OFF]};
        curStream = {hdrNext[STREAM_OFF+1], hdrNext[STREAM_OFF]};
        curSeq    = {hdrNext[SEQ_OFF+3], hdrNext[SEQ_OFF+2], hdrNext[SEQ_OFF+1], hdrNext[SEQ_OFF]};
        for (int j = 0; j < OUT_BYTES; j++) begin
            for (int k = 0; k < BEAT_BYTES; k++) begin
                if (base + 32'(k) == 32'(j + HDR_BYTES) && base + 32'(k) < 32'(curLen))
                    payNext[8*OUT_BYTES-1-8*j -: 8] = dataIn[8*BEAT_BYTES-1-8*k -: 8];
            end
        end
    end

    // Length bookkeeping for a message ending on the current beat.
    always_comb begin
        recv      = base + 32'(BEAT_BYTES);
        avail     = (recv < 32'(curLen)) ? recv : 32'(curLen);
        payRecv   = (avail > 32'(HDR_BYTES)) ? avail - 32'(HDR_BYTES) : 32'd0;
        curTrunc  = payRecv > 32'(OUT_BYTES);
        curOutLen = curTrunc ? 16'(OUT_BYTES) : payRecv[15:0];
        expBeats  = (32'(curLen) + 32'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
        curLenErr = (32'(beatCnt) + 32'd1 != expBeats) || (curLen < 16'(HDR_BYTES))
                    || (beatCnt < 17'(HDR_BEATS - 1));
        if (hdrFinal)                         curFlags = tblFlags;
        else if (beatCnt < 17'(HDR_BEATS))    curFlags = '0;
        else                                  curFlags = tblFlagReg;
        msgFlags           = curFlags;
        msgFlags.lenErr    = curLenErr;
        msgFlags.truncated = curTrunc;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_HDR: begin
                if (lastFire)      stateNext = outFree ? ST_HDR : ST_HOLD;
                else if (hdrFinal) stateNext = ST_BODY;
            end
            ST_BODY: if (lastFire) stateNext = outFree ? ST_HDR : ST_HOLD;
            ST_HOLD: if (outFree)  stateNext = ST_HDR;
            default:               stateNext = ST_HDR;
        endcase
    end

    stream_seq_table #(
        .NUM_STREAMS(NUM_STREAMS)
    ) table_i (
        .clk         (clk),
        .reset       (reset),
        .lookupEn    (hdrFinal),
        .lookupStream(curStream),
        .lookupSeq   (curSeq),
        .flags       (tblFlags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_HDR;
            beatCnt    <= '0;
            hdrReg     <= '0;
            payBuf     <= '0;
            tblFlagReg <= '0;
        end else begin
            state <= stateNext;
            if (fire) begin
                hdrReg  <= hdrNext;
                payBuf  <= payNext;
                beatCnt <= dataIn_last ? '0 : ((&beatCnt) ? beatCnt : beatCnt + 1'b1);
                if (hdrFinal) tblFlagReg <= tblFlags;
            end
        end
    end

    // A completed message goes straight to the output when it is free,
    // otherwise it waits in the pending registers while the FSM holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut        <= '0;
            dataOut_stream <= '0;
            dataOut_seq    <= '0;
            dataOut_len    <= '0;
            dataOut_val    <= 1'b0;
            outFlags       <= '0;
            pendLen        <= '0;
            pendStream     <= '0;
            pendSeq        <= '0;
            pendFlags      <= '0;
        end else begin
            if (lastFire && outFree) begin
                dataOut        <= payNext;
                dataOut_stream <= curStream;
                dataOut_seq    <= curSeq;
                dataOut_len    <= curOutLen;
                outFlags       <= msgFlags;
                dataOut_val    <= 1'b1;
            end else if (state == ST_HOLD && outFree) begin
                dataOut        <= payBuf;
                dataOut_stream <= pendStream;
                dataOut_seq    <= pendSeq;
                dataOut_len    <= pendLen;
                outFlags       <= pendFlags;
                dataOut_val    <= 1'b1;
            end else if (dataOut_ready) begin
                dataOut_val <= 1'b0;
            end
            if (lastFire && !outFree) begin
                pendLen    <= curOutLen;
                pendStream <= curStream;
                pendSeq    <= curSeq;
                pendFlags  <= msgFlags;
            end
        end
    end

    assign packetLost = outFlags.packetLost;
    assign lostCount  = outFlags.lostCount;
    assign reorder    = outFlags.reorder;
    assign lenErr     = outFlags.lenErr;
    assign truncated  = outFlags.truncated;

endmodule
